// File: rtl/adc_sched_pkg.sv
// Shared FSM encoding, widths and timing defaults for the ADC scan scheduler.
package adc_sched_pkg;
    localparam int CH_W         = 3;
    localparam int SMP_W        = 12;
    localparam int TICK_DIV_DEF = 50;
    localparam int TMO_CYC_DEF  = 4095;

    typedef enum logic [1:0] {IDLE, START, WAIT, OUT} sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N_CH = 8,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] grant,
    output logic            any_req
);
    logic [CH_W:0] idx;

    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = {1'b0, ptr} + (CH_W+1)'(i);
            if (idx >= (CH_W+1)'(N_CH)) begin
                idx = idx - (CH_W+1)'(N_CH);
            end
            if (!any_req && req[idx[CH_W-1:0]]) begin
                any_req = 1'b1;
                grant   = idx[CH_W-1:0];
            end
        end
    end
endmodule

// File: rtl/adc_scan_sched.sv
// Per-channel periodic sampling scheduler feeding a single ADC conversion engine
// and forwarding each result on a valid/ready sample stream.
module adc_scan_sched
    import adc_sched_pkg::*;
#(
    parameter int N_CH     = 8,
    parameter int PER_W    = 16,
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int TMO_CYC  = TMO_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [N_CH-1:0]  ch_mask,
    input  logic             per_we,
    input  logic [CH_W-1:0]  per_ch,
    input  logic [PER_W-1:0] per_val,
    input  logic             ovr_clr,
    output logic             conv_start,
    output logic [CH_W-1:0]  conv_ch,
    input  logic             conv_done,
    input  logic [SMP_W-1:0] conv_value,
    output logic             smp_valid,
    output logic [CH_W-1:0]  smp_ch,
    output logic [SMP_W-1:0] smp_data,
    input  logic             smp_ready,
    output logic [N_CH-1:0]  overrun,
    output logic             tmo_err
);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TMO_W = $clog2(TMO_CYC + 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick;
    logic [PER_W-1:0] cnt_q [N_CH];
    logic [PER_W-1:0] cnt_d [N_CH];
    logic [PER_W-1:0] per_q [N_CH];
    logic [PER_W-1:0] per_d [N_CH];
    logic [N_CH-1:0]  pending_q, pending_d;
    logic [N_CH-1:0]  overrun_q, overrun_d;

    sched_state_t     state_q;
    logic [CH_W-1:0]  rr_ptr_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             conv_start_q, smp_valid_q, tmo_err_q;
    logic [CH_W-1:0]  conv_ch_q, smp_ch_q;
    logic [SMP_W-1:0] smp_data_q;

    logic [CH_W-1:0]  grant;
    logic             any_req;
    logic             grant_fire;

    rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
        .req     (pending_q & ch_mask),
        .ptr     (rr_ptr_q),
        .grant   (grant),
        .any_req (any_req)
    );

    assign grant_fire = (state_q == IDLE) && enable && any_req;
    assign tick       = (pre_q == PRE_W'(TICK_DIV - 1));

    always_comb begin
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    // Due events set pending after the grant clears it, so a same-cycle due wins.
    always_comb begin
        cnt_d     = cnt_q;
        per_d     = per_q;
        pending_d = pending_q;
        overrun_d = ovr_clr ? '0 : overrun_q;
        if (grant_fire) begin
            pending_d[grant] = 1'b0;
        end
        for (int i = 0; i < N_CH; i++) begin
            if (!ch_mask[i]) begin
                cnt_d[i]     = '0;
                pending_d[i] = 1'b0;
            end else if (tick && enable && !(per_we && per_ch == CH_W'(i))) begin
                if (cnt_q[i] == '0) begin
                    cnt_d[i]     = per_q[i];
                    pending_d[i] = 1'b1;
                    if (pending_q[i] && !(grant_fire && grant == CH_W'(i))) begin
                        overrun_d[i] = 1'b1;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end
            end
        end
        if (per_we) begin
            per_d[per_ch] = per_val;
            if (ch_mask[per_ch]) begin
                cnt_d[per_ch] = per_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q     <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
                per_q[i] <= '0;
            end
        end else begin
            pre_q     <= pre_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
        end
    end

    // Timeout fires on the last counted WAIT cycle so tmo_err lands TMO_CYC+1 after start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            tmo_cnt_q    <= '0;
            conv_start_q <= 1'b0;
            conv_ch_q    <= '0;
            smp_valid_q  <= 1'b0;
            smp_ch_q     <= '0;
            smp_data_q   <= '0;
            tmo_err_q    <= 1'b0;
        end else begin
            conv_start_q <= 1'b0;
            tmo_err_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant_fire) begin
                        conv_ch_q    <= grant;
                        rr_ptr_q     <= (grant == CH_W'(N_CH - 1)) ? '0 : grant + 1'b1;
                        conv_start_q <= 1'b1;
                        state_q      <= START;
                    end
                end
                START: begin
                    tmo_cnt_q <= TMO_W'(TMO_CYC);
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (conv_done) begin
                        smp_data_q  <= conv_value;
                        smp_ch_q    <= conv_ch_q;
                        smp_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else if (tmo_cnt_q == TMO_W'(1)) begin
                        tmo_err_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q - 1'b1;
                    end
                end
                OUT: begin
                    if (smp_ready) begin
                        smp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign conv_start = conv_start_q;
    assign conv_ch    = conv_ch_q;
    assign smp_valid  = smp_valid_q;
    assign smp_ch     = smp_ch_q;
    assign smp_data   = smp_data_q;
    assign overrun    = overrun_q;
    assign tmo_err    = tmo_err_q;
endmodule

// File: tb/tb_adc_scan_sched.sv
// Bench for adc_scan_sched: directed scenarios plus a randomized run, all checked
// cycle by cycle against a tick-index / timestamp model of the scheduler.
module tb_adc_scan_sched;
    localparam int N_CH     = 8;
    localparam int TICK_DIV = 50;
    localparam int TMO_CYC  = 4095;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  ch_mask = '0;
    logic        per_we = 1'b0;
    logic [2:0]  per_ch = '0;
    logic [15:0] per_val = '0;
    logic        ovr_clr = 1'b0;
    logic        conv_start;
    logic [2:0]  conv_ch;
    logic        conv_done = 1'b0;
    logic [11:0] conv_value = '0;
    logic        smp_valid;
    logic [2:0]  smp_ch;
    logic [11:0] smp_data;
    logic        smp_ready = 1'b0;
    logic [7:0]  overrun;
    logic        tmo_err;

    always #5 clk = ~clk;

    adc_scan_sched dut (
        .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
        .per_we(per_we), .per_ch(per_ch), .per_val(per_val), .ovr_clr(ovr_clr),
        .conv_start(conv_start), .conv_ch(conv_ch), .conv_done(conv_done),
        .conv_value(conv_value), .smp_valid(smp_valid), .smp_ch(smp_ch),
        .smp_data(smp_data), .smp_ready(smp_ready), .overrun(overrun), .tmo_err(tmo_err)
    );

    int checks = 0;
    int failures = 0;

    // Model: m_nd[i] is the enabled-tick index at which channel i next becomes due.
    int       m_c, m_etk, m_start, m_ch, m_rr, m_sch, m_sdata;
    bit       m_busy, m_have, m_tmo;
    bit [7:0] m_pend, m_ovr;
    int       m_nd [N_CH];
    int       m_per [N_CH];

    bit rand_mode, no_done_once, pw_req, clr_req;
    int ready_mode, lat_min, lat_max, fixed_val, tmo_budget, eng_left;
    int pw_ch, pw_val, first_data, first_smp_c;
    int starts_q[$], chs_q[$], tmo_q[$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d got=0x%0h required=0x%0h", name, m_c, actual, expected);
        end
    endtask

    function automatic int qAt(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic modelReset();
        m_c = 0; m_etk = 0; m_start = -1; m_ch = 0; m_rr = 0; m_sch = 0; m_sdata = 0;
        m_busy = 0; m_have = 0; m_tmo = 0; m_pend = '0; m_ovr = '0;
        for (int i = 0; i < N_CH; i++) begin
            m_nd[i] = 0;
            m_per[i] = 0;
        end
    endtask

    task automatic modelStep();
        int       gnt;
        bit       tick, etick;
        bit [7:0] req, pend_n, set_ovr;
        gnt = -1;
        req = m_pend & ch_mask;
        if (!m_busy && !m_have && enable && req != 0) begin
            for (int k = 0; k < N_CH; k++) begin
                if (gnt < 0 && req[(m_rr + k) % N_CH]) gnt = (m_rr + k) % N_CH;
            end
        end
        tick  = (m_c % TICK_DIV) == TICK_DIV - 1;
        etick = tick && enable;
        m_tmo = 0;
        if (m_busy && m_c > m_start) begin
            if (conv_done) begin
                m_have = 1; m_sch = m_ch; m_sdata = conv_value; m_busy = 0;
            end else if (m_c == m_start + TMO_CYC) begin
                m_tmo = 1; m_busy = 0;
            end
        end else if (m_have && smp_ready) begin
            m_have = 0;
        end
        pend_n  = m_pend;
        set_ovr = '0;
        if (gnt >= 0) begin
            pend_n[gnt] = 0;
            m_busy = 1; m_start = m_c + 1; m_ch = gnt; m_rr = (gnt + 1) % N_CH;
        end
        for (int i = 0; i < N_CH; i++) begin
            if (!ch_mask[i]) begin
                pend_n[i] = 0;
                m_nd[i] = m_etk + int'(etick);
            end else if (etick && !(per_we && per_ch == i) && m_nd[i] == m_etk) begin
                if (m_pend[i] && gnt != i) set_ovr[i] = 1;
                pend_n[i] = 1;
                m_nd[i] = m_etk + 1 + m_per[i];
            end
        end
        if (per_we) begin
            m_per[per_ch] = per_val;
            if (ch_mask[per_ch]) m_nd[per_ch] = m_etk + int'(etick) + int'(per_val);
        end
        m_ovr  = (ovr_clr ? 8'h00 : m_ovr) | set_ovr;
        m_pend = pend_n;
        m_etk  = m_etk + int'(etick);
        m_c++;
    endtask

    task automatic compareAll();
        checkOutput("conv_start", conv_start, int'(m_busy && m_c == m_start));
        checkOutput("conv_ch", conv_ch, m_ch);
        checkOutput("smp_valid", smp_valid, m_have);
        if (m_have) begin
            checkOutput("smp_ch", smp_ch, m_sch);
            checkOutput("smp_data", smp_data, m_sdata);
        end
        checkOutput("overrun", overrun, m_ovr);
        checkOutput("tmo_err", tmo_err, m_tmo);
        if (conv_start) begin
            starts_q.push_back(m_c);
            chs_q.push_back(conv_ch);
        end
        if (tmo_err) tmo_q.push_back(m_c);
        if (smp_valid && first_data < 0) first_data = smp_data;
        if (smp_valid && first_smp_c < 0) first_smp_c = m_c;
    endtask

    // Engine emulation follows the model's expected conv_start, never the DUT's.
    task automatic applyStimulus();
        per_we = 0; ovr_clr = 0; conv_done = 0;
        if (rand_mode) begin
            if ($urandom_range(0, 149) == 0) ch_mask = 8'($urandom);
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            if ($urandom_range(0, 59) == 0) begin
                pw_req = 1; pw_ch = $urandom_range(0, 7); pw_val = $urandom_range(0, 7);
            end
            if ($urandom_range(0, 99) == 0) clr_req = 1;
        end
        if (pw_req) begin
            per_we = 1; per_ch = 3'(pw_ch); per_val = 16'(pw_val); pw_req = 0;
        end
        if (clr_req) begin
            ovr_clr = 1; clr_req = 0;
        end
        case (ready_mode)
            0:       smp_ready = 1'b1;
            1:       smp_ready = 1'($urandom_range(0, 1));
            default: smp_ready = 1'b0;
        endcase
        if (eng_left > 0) begin
            eng_left--;
            if (eng_left == 0) begin
                conv_done  = 1;
                conv_value = (fixed_val >= 0) ? 12'(fixed_val) : 12'($urandom);
            end
        end else if (!m_busy && $urandom_range(0, 63) == 0) begin
            conv_done  = 1;
            conv_value = 12'($urandom);
        end
        if (m_busy && m_c == m_start) begin
            if (no_done_once) begin
                eng_left = -1; no_done_once = 0;
            end else if (tmo_budget > 0 && $urandom_range(0, 39) == 0) begin
                eng_left = -1; tmo_budget--;
            end else begin
                eng_left = $urandom_range(lat_min, lat_max);
            end
        end
    endtask

    task automatic step();
        compareAll();
        applyStimulus();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1; conv_done = 0; per_we = 0; ovr_clr = 0;
        #1;
        checkOutput("rst_conv_start", conv_start, 0);
        checkOutput("rst_conv_ch", conv_ch, 0);
        checkOutput("rst_smp_valid", smp_valid, 0);
        checkOutput("rst_smp_ch", smp_ch, 0);
        checkOutput("rst_smp_data", smp_data, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_tmo_err", tmo_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        modelReset();
        starts_q.delete(); chs_q.delete(); tmo_q.delete();
        first_data = -1; first_smp_c = -1;
    endtask

    initial begin
        bit found;
        rand_mode = 0; no_done_once = 0; pw_req = 0; clr_req = 0; eng_left = 0;
        ready_mode = 0; lat_min = 10; lat_max = 10; fixed_val = 'h5A3; tmo_budget = 0;
        modelReset();
        first_data = -1; first_smp_c = -1;
        @(negedge clk);

        // Single channel, period 4: starts every 250 clocks.
        doReset();
        ch_mask = 8'h01; enable = 1; pw_req = 1; pw_ch = 0; pw_val = 4;
        for (int k = 0; k < 520; k++) step();
        checkOutput("A_start0", qAt(starts_q, 0), 251);
        checkOutput("A_start1", qAt(starts_q, 1), 501);
        checkOutput("A_ch0", qAt(chs_q, 0), 0);
        checkOutput("A_data", first_data, 'h5A3);
        checkOutput("A_overrun", overrun, 0);

        // All channels, period 0, slow engine: strict rotation and overruns everywhere.
        lat_min = 20; lat_max = 20; fixed_val = -1;
        doReset();
        ch_mask = 8'hFF; enable = 1;
        for (int k = 0; k < 700; k++) step();
        for (int k = 0; k < 9; k++) checkOutput("B_order", qAt(chs_q, k), k % 8);
        checkOutput("B_overrun", overrun, 'hFF);

        // Engine never answers the first start: timeout then the next channel.
        lat_min = 10; lat_max = 10; no_done_once = 1;
        doReset();
        ch_mask = 8'h03; enable = 1;
        for (int k = 0; k < 4300; k++) step();
        checkOutput("C_tmo_delay", qAt(tmo_q, 0) - qAt(starts_q, 0), TMO_CYC + 1);
        checkOutput("C_tmo_cycle", qAt(tmo_q, 0), 4147);
        checkOutput("C_tmo_count", tmo_q.size(), 1);
        checkOutput("C_next_start", qAt(starts_q, 1), 4148);
        checkOutput("C_next_ch", qAt(chs_q, 1), 1);

        // Back-pressure: sample held, no new start, overrun set then cleared.
        fixed_val = 'h3C1; ready_mode = 2;
        doReset();
        ch_mask = 8'h01; enable = 1;
        for (int k = 0; k < 400; k++) begin
            if (k == 200) begin
                checkOutput("D_hold_valid", smp_valid, 1);
                checkOutput("D_hold_data", smp_data, 'h3C1);
                checkOutput("D_overrun_set", overrun, 1);
            end
            if (k == 299) checkOutput("D_no_start", starts_q.size(), 1);
            if (k == 300) ready_mode = 0;
            if (k == 320) clr_req = 1;
            if (k == 330) checkOutput("D_overrun_clr", overrun, 0);
            step();
        end

        // Period write to ch 2 coinciding with its first (cnt=0) tick.
        fixed_val = -1;
        doReset();
        ch_mask = 8'h04; enable = 1;
        for (int k = 0; k < 600; k++) begin
            if (k == 49) begin
                pw_req = 1; pw_ch = 2; pw_val = 9;
            end
            step();
        end
        checkOutput("E_start", qAt(starts_q, 0), 551);
        checkOutput("E_ch", qAt(chs_q, 0), 2);

        // Randomized traffic, then a reset in the middle of a conversion.
        ready_mode = 1; lat_min = 1; lat_max = 30; tmo_budget = 1;
        doReset();
        ch_mask = 8'hFF; enable = 1; rand_mode = 1;
        for (int k = 0; k < 8000; k++) step();
        rand_mode = 0; ch_mask = 8'hFF; enable = 1;
        found = 0;
        for (int k = 0; k < 6000 && !found; k++) begin
            if (m_busy && m_c > m_start + 1 && eng_left > 1) found = 1;
            else step();
        end
        checkOutput("F_found_wait", found, 1);
        doReset();
        for (int k = 0; k < 300; k++) step();
        checkOutput("F_late_done_ignored", int'(first_smp_c < 0 || first_smp_c > 51), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
